// File: rtl/audio_adc_rx.sv
// I2S ADC capture: deserializes stereo sample pairs on the bit-clock rising edge
// and buffers them in a small FIFO drained through a valid/ready handshake.
module audio_adc_rx #(
   parameter int unsigned SAMPLE_BITS = 16,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                   clk12,
   input  logic                   reset12,
   input  logic                   enable,
   input  logic                   adc_bclk,
   input  logic                   adc_lrc,
   input  logic                   adc_dat,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [SAMPLE_BITS-1:0] out_left,
   output logic [SAMPLE_BITS-1:0] out_right,
   output logic                   overrun,
   output logic                   frame_err,
   input  logic                   err_clr
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned PW = AW + 1;
   localparam int unsigned CW = 6;

   typedef enum logic [1:0] {IDLE, SYNC, LEFT, RIGHT} state_t;

   state_t                 state;
   logic                   bclk_q;
   logic                   lrc_prev;
   logic                   bad;
   logic [CW-1:0]          bit_cnt;
   logic [SAMPLE_BITS-1:0] sr_left;
   logic [SAMPLE_BITS-1:0] sr_right;
   logic [SAMPLE_BITS-1:0] mem_left  [FIFO_DEPTH];
   logic [SAMPLE_BITS-1:0] mem_right [FIFO_DEPTH];
   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;

   logic          rise;
   logic [CW-1:0] bit_idx;
   logic          in_sample;
   logic          short_slot;
   logic          exit_left;
   logic          exit_right;
   logic          push;
   logic          pop;
   logic          full;
   logic          empty;
   logic          wr_en;
   logic          drop;
   logic          frame_set;

   assign rise       = adc_bclk & ~bclk_q;
   // Index of the bit sampled on this rise, saturating with the counter.
   assign bit_idx    = (bit_cnt == CW'(63)) ? CW'(63) : bit_cnt + CW'(1);
   assign in_sample  = (bit_idx <= CW'(SAMPLE_BITS));
   assign short_slot = (bit_cnt < CW'(SAMPLE_BITS));

   assign exit_left  = enable & rise & (state == LEFT)  &  adc_lrc;
   assign exit_right = enable & rise & (state == RIGHT) & ~adc_lrc;
   assign push       = exit_right & ~bad & ~short_slot;
   assign frame_set  = (exit_left | exit_right) & short_slot;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign out_valid = ~empty;
   assign pop       = out_valid & out_ready;
   assign wr_en     = push & (~full | pop);
   assign drop      = push & full & ~pop;

   assign out_left  = mem_left[rd_ptr[AW-1:0]];
   assign out_right = mem_right[rd_ptr[AW-1:0]];

   // Frame tracking and deserialization; enable low forces IDLE on any cycle.
   always_ff @(posedge clk12 or posedge reset12) begin
      if (reset12) begin
         state    <= IDLE;
         bclk_q   <= 1'b0;
         lrc_prev <= 1'b0;
         bad      <= 1'b0;
         bit_cnt  <= '0;
         sr_left  <= '0;
         sr_right <= '0;
      end else begin
         bclk_q <= adc_bclk;
         if (rise) lrc_prev <= adc_lrc;
         if (!enable) begin
            state <= IDLE;
         end else if (rise) begin
            case (state)
               IDLE: state <= SYNC;
               SYNC: begin
                  if (!adc_lrc && lrc_prev) begin
                     state   <= LEFT;
                     bit_cnt <= '0;
                     bad     <= 1'b0;
                  end
               end
               LEFT: begin
                  if (adc_lrc) begin
                     state   <= RIGHT;
                     bit_cnt <= '0;
                     if (short_slot) bad <= 1'b1;
                  end else begin
                     bit_cnt <= bit_idx;
                     if (in_sample) sr_left <= {sr_left[SAMPLE_BITS-2:0], adc_dat};
                  end
               end
               RIGHT: begin
                  if (!adc_lrc) begin
                     state   <= LEFT;
                     bit_cnt <= '0;
                     bad     <= 1'b0;
                  end else begin
                     bit_cnt <= bit_idx;
                     if (in_sample) sr_right <= {sr_right[SAMPLE_BITS-2:0], adc_dat};
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Pair FIFO and sticky error flags; a set outranks a simultaneous clear.
   always_ff @(posedge clk12 or posedge reset12) begin
      if (reset12) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            mem_left[i]  <= '0;
            mem_right[i] <= '0;
         end
      end else begin
         if (wr_en) begin
            mem_left[wr_ptr[AW-1:0]]  <= sr_left;
            mem_right[wr_ptr[AW-1:0]] <= sr_right;
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         if (drop)         overrun <= 1'b1;
         else if (err_clr) overrun <= 1'b0;
         if (frame_set)    frame_err <= 1'b1;
         else if (err_clr) frame_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_audio_adc_rx.sv
// Bench for audio_adc_rx: directed I2S frames, scoreboard queue checked by a
// monitor on every accepted output pair.
module tb_audio_adc_rx;
   localparam int unsigned SB = 16;

   logic          clk12 = 1'b0;
   logic          reset12;
   logic          enable;
   logic          adc_bclk;
   logic          adc_lrc;
   logic          adc_dat;
   logic          out_valid;
   logic          out_ready;
   logic [SB-1:0] out_left;
   logic [SB-1:0] out_right;
   logic          overrun;
   logic          frame_err;
   logic          err_clr;

   int            n_cmp = 0;
   int            n_bad = 0;
   int            pop_count = 0;
   int            pops_before;
   logic [31:0]   exp_q[$];
   logic [31:0]   mon_exp;

   audio_adc_rx #(.SAMPLE_BITS(SB), .FIFO_DEPTH(4)) dut (
      .clk12(clk12), .reset12(reset12), .enable(enable),
      .adc_bclk(adc_bclk), .adc_lrc(adc_lrc), .adc_dat(adc_dat),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_left(out_left), .out_right(out_right),
      .overrun(overrun), .frame_err(frame_err), .err_clr(err_clr)
   );

   always #5 clk12 = ~clk12;

   // Monitor: every accepted pair must match the head of the expected queue.
   always @(negedge clk12) begin
      if (!reset12 && out_valid && out_ready) begin
         n_cmp++;
         pop_count++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_pair: got %h/%h, expected none", out_left, out_right);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({out_left, out_right} !== mon_exp) begin
               n_bad++;
               $display("FAIL pair: got %h/%h, expected %h/%h",
                        out_left, out_right, mon_exp[31:16], mon_exp[15:0]);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // All tasks start and end 1 time unit after a rising clk12 edge.
   task automatic bit_clk(input logic l, input logic d);
      adc_bclk = 1'b0;
      adc_lrc  = l;
      adc_dat  = d;
      repeat (2) @(posedge clk12);
      #1 adc_bclk = 1'b1;
      repeat (2) @(posedge clk12);
      #1;
   endtask

   // Slot of n bit clocks: index 0 is the delay bit, then MSB-first sample, then padding.
   task automatic send_slot(input logic l, input logic [SB-1:0] s, input int n);
      for (int k = 0; k < n; k++)
         bit_clk(l, (k >= 1 && k <= int'(SB)) ? s[int'(SB) - k] : 1'b0);
   endtask

   task automatic send_frame(input logic [SB-1:0] l, input logic [SB-1:0] r);
      send_slot(1'b0, l, 32);
      send_slot(1'b1, r, 32);
   endtask

   // Drop enable, re-enable, and lead with a dummy right slot.
   task automatic start_stream();
      enable = 1'b0;
      repeat (2) @(posedge clk12);
      #1 enable = 1'b1;
      send_slot(1'b1, '0, 32);
   endtask

   task automatic close_stream();
      send_slot(1'b0, '0, 2);
   endtask

   // Completing rise with out_ready / err_clr held high for exactly that cycle.
   task automatic close_special(input logic rdy, input logic clr);
      adc_bclk = 1'b0;
      adc_lrc  = 1'b0;
      adc_dat  = 1'b0;
      repeat (2) @(posedge clk12);
      #1;
      adc_bclk  = 1'b1;
      out_ready = rdy;
      err_clr   = clr;
      @(posedge clk12);
      #1;
      out_ready = 1'b0;
      err_clr   = 1'b0;
      @(posedge clk12);
      #1;
   endtask

   task automatic drain(input int cycles);
      out_ready = 1'b1;
      repeat (cycles) @(posedge clk12);
      #1 out_ready = 1'b0;
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      @(posedge clk12);
      #1 err_clr = 1'b0;
   endtask

   initial begin
      reset12 = 1'b1; enable = 1'b0; adc_bclk = 1'b0; adc_lrc = 1'b0;
      adc_dat = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
      repeat (3) @(posedge clk12);
      #1;
      check("reset_valid", 32'(out_valid), 32'd0);
      check("reset_left", 32'(out_left), 32'd0);
      check("reset_right", 32'(out_right), 32'd0);
      check("reset_overrun", 32'(overrun), 32'd0);
      check("reset_frame_err", 32'(frame_err), 32'd0);
      reset12 = 1'b0;
      @(posedge clk12);
      #1;

      // Basic capture
      start_stream();
      exp_q.push_back({16'h1234, 16'hABCD});
      send_frame(16'h1234, 16'hABCD);
      close_stream();
      check("basic_valid", 32'(out_valid), 32'd1);
      check("basic_left", 32'(out_left), 32'h1234);
      check("basic_right", 32'(out_right), 32'hABCD);
      check("basic_overrun", 32'(overrun), 32'd0);
      check("basic_frame_err", 32'(frame_err), 32'd0);
      drain(3);
      check("basic_empty", 32'(out_valid), 32'd0);

      // Overrun: five frames into a four-deep FIFO
      start_stream();
      for (int i = 0; i < 5; i++) begin
         if (i < 4) exp_q.push_back({16'(16'h1000 + i), 16'(16'h2000 + i)});
         send_frame(16'(16'h1000 + i), 16'(16'h2000 + i));
      end
      close_stream();
      check("ovr_flag", 32'(overrun), 32'd1);
      check("ovr_frame_err", 32'(frame_err), 32'd0);
      drain(8);
      check("ovr_empty", 32'(out_valid), 32'd0);
      pulse_clr();
      check("ovr_cleared", 32'(overrun), 32'd0);

      // Short left slot, then a good frame
      start_stream();
      send_slot(1'b0, 16'h1111, 10);
      send_slot(1'b1, 16'h2222, 32);
      check("short_flag", 32'(frame_err), 32'd1);
      check("short_not_pushed", 32'(out_valid), 32'd0);
      exp_q.push_back({16'h7FFF, 16'h8000});
      send_frame(16'h7FFF, 16'h8000);
      close_stream();
      check("short_next_left", 32'(out_left), 32'h7FFF);
      check("short_next_right", 32'(out_right), 32'h8000);
      drain(3);
      pulse_clr();
      check("short_cleared", 32'(frame_err), 32'd0);

      // Enable drop during bit 5 of the right slot
      start_stream();
      send_slot(1'b0, 16'h1357, 32);
      send_slot(1'b1, 16'h2468, 5);
      enable = 1'b0;
      repeat (3) @(posedge clk12);
      #1 enable = 1'b1;
      send_slot(1'b1, '0, 27);
      check("en_no_push", 32'(out_valid), 32'd0);
      exp_q.push_back({16'h5A5A, 16'h0F0F});
      send_frame(16'h5A5A, 16'h0F0F);
      close_stream();
      check("en_frame_err", 32'(frame_err), 32'd0);
      drain(3);

      // Push and pop together on a full FIFO
      start_stream();
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back({16'(16'h3000 + i), 16'(16'h4000 + i)});
         send_frame(16'(16'h3000 + i), 16'(16'h4000 + i));
      end
      close_special(1'b1, 1'b0);
      check("sim_no_overrun", 32'(overrun), 32'd0);
      pops_before = pop_count;
      drain(8);
      check("sim_count", 32'(pop_count - pops_before), 32'd4);

      // err_clr in the overrun cycle: the set wins
      start_stream();
      for (int i = 0; i < 5; i++) begin
         if (i < 4) exp_q.push_back({16'(16'h5000 + i), 16'(16'h6000 + i)});
         send_frame(16'(16'h5000 + i), 16'(16'h6000 + i));
      end
      close_special(1'b0, 1'b1);
      check("clr_vs_set", 32'(overrun), 32'd1);
      drain(8);
      pulse_clr();
      check("clr_after", 32'(overrun), 32'd0);

      // Asynchronous reset at bit 8 of a left slot with a pair buffered
      start_stream();
      send_frame(16'hCAFE, 16'hBEEF);
      send_slot(1'b0, 16'h1111, 8);
      check("pre_reset_valid", 32'(out_valid), 32'd1);
      reset12 = 1'b1;
      #2;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_left", 32'(out_left), 32'd0);
      check("rst_right", 32'(out_right), 32'd0);
      check("rst_flags", 32'({overrun, frame_err}), 32'd0);
      adc_bclk = 1'b0; adc_lrc = 1'b0; adc_dat = 1'b0;
      @(posedge clk12);
      #1 reset12 = 1'b0;
      start_stream();
      exp_q.push_back({16'h0001, 16'hFFFF});
      send_frame(16'h0001, 16'hFFFF);
      close_stream();
      drain(3);

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("final_empty", 32'(out_valid), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
